ps2_host_transmitter: RTL

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 "enable data reporting", 0xFF "reset") from the FPGA to the attached mouse over the shared open-drain `ps2c_io`/`ps2d_io` lines. It is the counterpart of the mouse receive path. It performs the request-to-send sequence, shifts out data and parity on device-generated clock edges, and checks the device's acknowledge bit. `tx_idle_o` gates the receiver so the two never drive or interpret the lines simultaneously.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_line_filter.sv | 43 ++++
 rtl/ps2_host_transmitter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/response bytes
// and the default timing constants at a 100 MHz system clock.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RTS,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_ACK,
    ST_RELEASE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;

  localparam int PS2_RTS_CYCLES     = 13000;
  localparam int PS2_TIMEOUT_CYCLES = 2000000;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus an N-sample agreement filter for one PS/2 line;
// emits the filtered level and a one-cycle falling-edge tick.
module ps2_line_filter #(
  parameter int DEPTH = 8
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [1:0]       sync_q;
  logic [DEPTH-1:0] hist_q;
  logic [DEPTH-1:0] hist_nxt;

  if (DEPTH > 1) begin : g_shift
    assign hist_nxt = {hist_q[DEPTH-2:0], sync_q[1]};
  end else begin : g_single
    assign hist_nxt = sync_q[1];
  end

  // Deciding on hist_nxt keeps the edge latency at 2+DEPTH cycles.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      hist_q  <= '1;
      level_o <= 1'b1;
      fall_o  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      hist_q <= hist_nxt;
      fall_o <= 1'b0;
      if (&hist_nxt) begin
        level_o <= 1'b1;
      end else if (~|hist_nxt) begin
        level_o <= 1'b0;
        fall_o  <= level_o;
      end
    end
  end

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter: request-to-send, 8 data bits plus
// odd parity clocked out on device falling edges, ack check, idle-gap timeout.
module ps2_host_transmitter
  import ps2_pkg::*;
#(
  parameter int RTS_CYCLES     = PS2_RTS_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
  parameter int FILTER_DEPTH   = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       wr_en_i,
  input  logic [7:0] din_i,
  inout  wire        ps2c_io,
  inout  wire        ps2d_io,
  output logic       tx_idle_o,
  output logic       tx_done_o,
  output logic       tx_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_tx_state_t state_q;
  logic [8:0]    sr_q;
  logic [13:0]   rts_cnt_q;
  logic [TW-1:0] gap_cnt_q;
  logic [3:0]    bit_cnt_q;
  logic          c_oe, d_oe;
  logic          ack_ok_q, done_q, err_q;
  logic          c_lvl, c_fall, d_lvl, d_fall_unused;
  logic          watching;

  ps2_line_filter #(.DEPTH(FILTER_DEPTH)) u_c_filt (
    .clk_i  (clk_i),
    .rst_n  (reset_i),
    .line_i (ps2c_io),
    .level_o(c_lvl),
    .fall_o (c_fall)
  );

  // Data only needs synchronizing; a depth-1 filter gives just that.
  ps2_line_filter #(.DEPTH(1)) u_d_filt (
    .clk_i  (clk_i),
    .rst_n  (reset_i),
    .line_i (ps2d_io),
    .level_o(d_lvl),
    .fall_o (d_fall_unused)
  );

  assign watching = (state_q != ST_IDLE) && (state_q != ST_RTS);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      rts_cnt_q <= '0;
      gap_cnt_q <= '0;
      bit_cnt_q <= '0;
      c_oe      <= 1'b0;
      d_oe      <= 1'b0;
      ack_ok_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      gap_cnt_q <= c_fall ? '0 : gap_cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          c_oe      <= 1'b0;
          d_oe      <= 1'b0;
          gap_cnt_q <= '0;
          if (wr_en_i) begin
            sr_q      <= {~^din_i, din_i};
            rts_cnt_q <= '0;
            bit_cnt_q <= '0;
            c_oe      <= 1'b1;
            state_q   <= ST_RTS;
          end
        end
        ST_RTS: begin
          rts_cnt_q <= rts_cnt_q + 1'b1;
          gap_cnt_q <= '0;
          // Start bit goes down one cycle ahead of the clock release.
          if (rts_cnt_q == 14'(RTS_CYCLES - 2)) d_oe <= 1'b1;
          if (rts_cnt_q == 14'(RTS_CYCLES - 1)) begin
            c_oe    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: if (c_fall) begin
          d_oe      <= ~sr_q[0];
          bit_cnt_q <= 4'd1;
          state_q   <= ST_DATA;
        end
        ST_DATA: if (c_fall) begin
          if (bit_cnt_q == 4'd9) begin
            d_oe    <= 1'b0;
            state_q <= ST_STOP;
          end else begin
            sr_q      <= sr_q >> 1;
            d_oe      <= ~sr_q[1];
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        ST_STOP: if (c_fall) begin
          ack_ok_q <= ~d_lvl;
          state_q  <= ST_ACK;
        end
        ST_ACK: begin
          gap_cnt_q <= '0;
          state_q   <= ST_RELEASE;
        end
        ST_RELEASE: if (c_lvl && d_lvl) begin
          done_q  <= ack_ok_q;
          err_q   <= ~ack_ok_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      // A silent device overrides whatever the protocol step was doing.
      if (watching && gap_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        c_oe    <= 1'b0;
        d_oe    <= 1'b0;
        done_q  <= 1'b0;
        err_q   <= 1'b1;
        state_q <= ST_IDLE;
      end
    end
  end

  assign ps2c_io   = c_oe ? 1'b0 : 1'bz;
  assign ps2d_io   = d_oe ? 1'b0 : 1'bz;
  assign tx_idle_o = (state_q == ST_IDLE);
  assign tx_done_o = done_q;
  assign tx_err_o  = err_q;

endmodule
